jtag_scan_master: RTL and testbench
===================================

JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 32, meaning the maximum scan length in bits (range 1..32).
REQ-002 The block SHALL have parameter TDO_LAT, default 1, meaning TCK cycles from TDI bit drive to its matching valid TDO bit (range 1..3).
REQ-003 The block SHALL have port TCK, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port TRST, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: scan request, sampled on the TCK rising edge.
REQ-006 The block SHALL have port is_ir, input, 1 bit: 1 requests an IR scan, 0 requests a DR scan; sampled with start.
REQ-007 The block SHALL have port len, input, 6 bits: number of bits to shift; sampled with start.
REQ-008 The block SHALL have port shift_in, input, 32 bits: data shifted out on TDI, LSB first; sampled with start.
REQ-009 The block SHALL have port shift_out, output, 32 bits: bits captured from TDO, with bit i matching TDI bit i; unused upper bits SHALL be 0.
REQ-010 The block SHALL have port busy, output, 1 bit: scan in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse flagging a rejected request.
REQ-013 The block SHALL have ports TMS (output, 1 bit), TDI (output, 1 bit) and TDO (input, 1 bit): the serial link to the target TAP.

Function
REQ-014 TMS and TDI SHALL be registered outputs.
REQ-015 While idle, the block SHALL drive TMS=0 and TDI=1, holding the TAP in Run-Test/Idle.
REQ-016 A request SHALL be accepted on an edge where start=1, busy=0 and 1<=len<=MAX_LEN; busy SHALL be 1 from that edge.
REQ-017 The first sequence value SHALL be driven in the cycle after the accepting edge, with one value per cycle after that.
- DR scan: TMS = 1,0,0, then the shift phase, then 1,0.
- IR scan: TMS = 1,1,0,0, then the shift phase, then 1,0.
REQ-018 The shift phase SHALL last len cycles, with TMS=0 on bits 0..len-2 and TMS=1 on bit len-1; len=1 therefore gives a single TMS=1 shift cycle.
REQ-019 During shift cycle i, TDI SHALL equal shift_in[i]; outside the shift phase TDI SHALL be 1.
REQ-020 shift_out[i] SHALL be TDO sampled TDO_LAT cycles after the cycle in which shift bit i is driven.
REQ-021 Total drive cycles SHALL be len+5 for DR and len+6 for IR.
REQ-022 done SHALL pulse for one cycle in the cycle after the final drive cycle (TMS=0), and busy SHALL fall on that same edge.
REQ-023 shift_out SHALL be cleared on acceptance, SHALL be valid from the done pulse, and SHALL hold until the next accepted request.
REQ-024 start with len=0 or len>MAX_LEN while idle SHALL produce no TMS activity, busy SHALL stay 0, and err SHALL pulse in the next cycle with done=0.
REQ-025 start while busy=1 SHALL be ignored with no error, and is_ir, len and shift_in SHALL be latched only at acceptance.
REQ-026 start=1 in the done cycle SHALL be accepted, so back-to-back scans are allowed with no Run-Test/Idle gap requirement.
REQ-027 The internal state machine SHALL use the states IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, plus RST_SEQ when RST_SEQ is compiled in; any illegal encoding SHALL return to IDLE.

Reset
REQ-028 While TRST=1, the block SHALL drive TMS=1, TDI=1, busy=0, done=0, err=0, shift_out=0 and the state machine SHALL enter its reset state, all asynchronously.
REQ-029 TRST asserted mid-scan SHALL abort the scan immediately with no done or err pulse, and the partial shift_out SHALL be discarded.
REQ-030 After TRST deasserts, the block SHALL leave its reset state on the first TCK rising edge.

Configuration
REQ-031 The block SHALL support macro JTAG_MASTER_RESET_SEQ_EN, compiled in or out.
- Defined: after reset the block SHALL drive TMS=1 for 5 cycles and then TMS=0 for 1 cycle (state RST_SEQ), with busy=1 throughout; start SHALL be ignored until busy falls, and no done pulse SHALL be produced.
- Undefined: the block SHALL enter IDLE on the first edge after reset, driving TMS=0, with busy=0.

Verification
REQ-032 DR scan, len=8, shift_in=0xA5, TDO looped from a 1-bit delayed TDI copy with TDO_LAT=1 -> TMS 1,0,0,0000000,1,1,0; TDI bits 1,0,1,0,0,1,0,1; shift_out=0xA5; done in cycle 14.
REQ-033 IR scan, len=5, shift_in=0x1F -> TMS 1,1,0,0,0000,1,1,0 (11 cycles); done pulse one cycle; busy high exactly 11 cycles.
REQ-034 len=0 and, separately, len=33 -> err pulse one cycle, busy=0, TMS stays 0, shift_out unchanged.
REQ-035 TRST asserted during shift bit 3 of a len=16 DR scan -> TMS=1, busy=0, shift_out=0 immediately; no done pulse.
REQ-036 start held high through the done cycle with len=1 -> second scan accepted at the done edge; its TMS 1,0,0,1,1,0 begins next cycle; start during busy is ignored.
REQ-037 With JTAG_MASTER_RESET_SEQ_EN defined, reset release -> TMS 1,1,1,1,1,0 with busy=1; start during this window is ignored; a scan is accepted afterwards.

Source files
------------

// File: rtl/jtag_scan_master_if.sv
// Request/response bundle between a scan client and jtag_scan_master.
// The client (master modport) issues start with the scan parameters.
// The scan engine (slave modport) returns the captured data and status pulses.
interface jtag_scan_master_if;
    logic        start;
    logic        is_ir;
    logic [5:0]  len;
    logic [31:0] shift_in;
    logic [31:0] shift_out;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, is_ir, len, shift_in,
        input  shift_out, busy, done, err
    );

    modport slave (
        input  start, is_ir, len, shift_in,
        output shift_out, busy, done, err
    );
endinterface

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: drives a single IR or DR scan through a target TAP,
// starting from Run-Test/Idle and returning to it. Bits are shifted LSB first.
// Captured TDO bits are collected into shift_out.
// Optional feature: define JTAG_MASTER_RESET_SEQ_EN to emit a TAP reset
// sequence (TMS=1 x5, then 0) after TRST is released.
module jtag_scan_master #(
    parameter int MAX_LEN = 32,   // longest scan accepted, 1..32
    parameter int TDO_LAT = 1     // TCK cycles from TDI drive to matching TDO, 1..3
) (
    input  logic                TCK,
    input  logic                TRST,
    jtag_scan_master_if.slave   bus,
    output logic                TMS,
    output logic                TDI,
    input  logic                TDO
);

    typedef enum logic [2:0] {
        IDLE,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT1,
        UPDATE
`ifdef JTAG_MASTER_RESET_SEQ_EN
        , RST_SEQ
`endif
    } state_t;

`ifdef JTAG_MASTER_RESET_SEQ_EN
    localparam state_t RESET_STATE = RST_SEQ;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;      // shift bit index / capture and reset-seq counter
    logic [5:0]  len_reg;
    logic        is_ir_reg;
    logic [31:0] sdata_reg;
    logic [31:0] shift_out_reg;
    logic [31:0] shift_out_mux;
    logic        tms_reg, tms_next;
    logic        tdi_reg, tdi_next;
    logic        busy_reg, done_reg, err_reg;
    logic        done_next, err_next;
    logic        accept;
    logic        len_ok;

    // Stage k says "bit pipe_idx_reg[k] was driven on TDI k cycles ago";
    // the last stage marks the cycle in which TDO carries that bit.
    logic [TDO_LAT:0] pipe_vld_reg;
    logic [4:0]       pipe_idx_reg [0:TDO_LAT];

    assign len_ok = (bus.len != 6'd0) && ({1'b0, bus.len} <= MAX_LEN_W);

    // Next-state and next-output decode; TMS/TDI values are for the phase being entered.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tms_next   = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        accept     = 1'b1;
                        state_next = SEL_DR;
                        cnt_next   = 5'd0;
                        tms_next   = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SEL_DR: begin
                if (is_ir_reg) begin
                    state_next = SEL_IR;
                    tms_next   = 1'b1;
                end else begin
                    state_next = CAPTURE;
                    cnt_next   = 5'd0;
                end
            end
            SEL_IR: begin
                state_next = CAPTURE;
                cnt_next   = 5'd0;
            end
            CAPTURE: begin
                // Two TMS=0 cycles: into Capture, then into Shift.
                if (cnt_reg == 5'd0) begin
                    cnt_next = 5'd1;
                end else begin
                    state_next = SHIFT;
                    cnt_next   = 5'd0;
                    tms_next   = (len_reg == 6'd1);
                end
            end
            SHIFT: begin
                if (({1'b0, cnt_reg} + 6'd1) == len_reg) begin
                    state_next = EXIT1;
                    tms_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                    tms_next = (({1'b0, cnt_reg} + 6'd2) == len_reg);
                end
            end
            EXIT1: begin
                state_next = UPDATE;
            end
            UPDATE: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
`ifdef JTAG_MASTER_RESET_SEQ_EN
            RST_SEQ: begin
                if (cnt_reg == 5'd6) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                    tms_next = (cnt_reg < 5'd5);
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
        tdi_next = (state_next == SHIFT) ? sdata_reg[cnt_next] : 1'b1;
    end

    // State, registered pin outputs, status pulses and request latch.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= 5'd0;
            tms_reg   <= 1'b1;
            tdi_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            len_reg   <= 6'd0;
            is_ir_reg <= 1'b0;
            sdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tms_reg   <= tms_next;
            tdi_reg   <= tdi_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (accept) begin
                len_reg   <= bus.len;
                is_ir_reg <= bus.is_ir;
                sdata_reg <= bus.shift_in;
            end
        end
    end

    // Track which shift bit each TDO cycle belongs to.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            pipe_vld_reg <= '0;
            for (int k = 0; k <= TDO_LAT; k++) begin
                pipe_idx_reg[k] <= 5'd0;
            end
        end else begin
            pipe_vld_reg[0] <= (state_next == SHIFT);
            pipe_idx_reg[0] <= cnt_next;
            for (int k = 1; k <= TDO_LAT; k++) begin
                pipe_vld_reg[k] <= pipe_vld_reg[k-1];
                pipe_idx_reg[k] <= pipe_idx_reg[k-1];
            end
        end
    end

    // Capture TDO into its bit slot; a new request clears the previous result.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            shift_out_reg <= 32'd0;
        end else if (accept) begin
            shift_out_reg <= 32'd0;
        end else if (pipe_vld_reg[TDO_LAT]) begin
            shift_out_reg[pipe_idx_reg[TDO_LAT]] <= TDO;
        end
    end

    // With the longest TDO latency the final bit arrives in the done cycle,
    // so the bit currently on TDO is merged in to make shift_out valid there.
    always_comb begin
        shift_out_mux = shift_out_reg;
        if (pipe_vld_reg[TDO_LAT]) begin
            shift_out_mux[pipe_idx_reg[TDO_LAT]] = TDO;
        end
    end

    assign TMS           = tms_reg;
    assign TDI           = tdi_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.shift_out = shift_out_mux;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master: TDO is a one-cycle delayed copy of TDI,
// so every scan must return its own shift_in in shift_out.
module tb_jtag_scan_master;

    logic TCK   = 1'b0;
    logic TRST  = 1'b0;
    logic tdo_q = 1'b1;
    logic tms;
    logic tdi;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] tms_v, tdi_v, busy_v, done_v, so_v;

    jtag_scan_master_if bus();

    jtag_scan_master #(
        .MAX_LEN (32),
        .TDO_LAT (1)
    ) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus),
        .TMS  (tms),
        .TDI  (tdi),
        .TDO  (tdo_q)
    );

    always #5 TCK = ~TCK;

    // Loopback target: TDO is TDI delayed by one TCK.
    always @(posedge TCK or posedge TRST) begin
        if (TRST) tdo_q <= 1'b1;
        else      tdo_q <= tdi;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    // Issue one request, then scramble the request inputs to prove they are
    // latched only at acceptance. Records cycles 1..ncyc after the accept edge
    // (bit c-1 of each vector = cycle c) and shift_out in cycle ncyc.
    task automatic run_scan(input logic ir, input logic [5:0] n, input logic [31:0] din,
                            input int ncyc,
                            output logic [31:0] t_v, output logic [31:0] d_v,
                            output logic [31:0] b_v, output logic [31:0] dn_v,
                            output logic [31:0] s_v);
        bus.start    = 1'b1;
        bus.is_ir    = ir;
        bus.len      = n;
        bus.shift_in = din;
        tick();
        bus.start    = 1'b0;
        bus.is_ir    = ~ir;
        bus.len      = 6'd3;
        bus.shift_in = ~din;
        t_v = '0; d_v = '0; b_v = '0; dn_v = '0; s_v = '0;
        for (int c = 0; c < ncyc; c++) begin
            t_v[c]  = tms;
            d_v[c]  = tdi;
            b_v[c]  = bus.busy;
            dn_v[c] = bus.done;
            if (c == ncyc - 1) s_v = bus.shift_out;
            tick();
        end
        $display("scan ir=%0d len=%0d din=0x%0h tms=0x%0h tdi=0x%0h busy=0x%0h done=0x%0h shift_out=0x%0h",
                 ir, n, din, t_v, d_v, b_v, dn_v, s_v);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.is_ir    = 1'b0;
        bus.len      = 6'd0;
        bus.shift_in = 32'd0;

        // Reset values while TRST is held
        #1 TRST = 1'b1;
        #7;
        check("rst_tms",  {31'd0, tms},       32'd1);
        check("rst_tdi",  {31'd0, tdi},       32'd1);
        check("rst_busy", {31'd0, bus.busy},  32'd0);
        check("rst_done", {31'd0, bus.done},  32'd0);
        check("rst_err",  {31'd0, bus.err},   32'd0);
        check("rst_so",   bus.shift_out,      32'd0);

`ifdef JTAG_MASTER_RESET_SEQ_EN
        // Reset sequence 1,1,1,1,1,0 with busy=1; a valid start is ignored meanwhile
        bus.start    = 1'b1;
        bus.len      = 6'd8;
        bus.shift_in = 32'hA5;
        #5 TRST = 1'b0;
        tms_v = '0; busy_v = '0; done_v = '0;
        for (int c = 0; c < 7; c++) begin
            tick();
            tms_v[c]  = tms;
            busy_v[c] = bus.busy;
            done_v[c] = bus.done;
            if (c == 5) bus.start = 1'b0;
        end
        $display("rstseq tms=0x%0h busy=0x%0h done=0x%0h", tms_v, busy_v, done_v);
        check("rstseq_tms",  tms_v,  32'h1F);
        check("rstseq_busy", busy_v, 32'h3F);
        check("rstseq_done", done_v, 32'h0);
`else
        // First edge after release enters Run-Test/Idle
        #5 TRST = 1'b0;
        tick();
        $display("release tms=%0d busy=%0d", tms, bus.busy);
        check("rel_tms",  {31'd0, tms},      32'd0);
        check("rel_busy", {31'd0, bus.busy}, 32'd0);
`endif

        // DR scan, len=8, 0xA5; done in cycle 14
        run_scan(1'b0, 6'd8, 32'hA5, 14, tms_v, tdi_v, busy_v, done_v, so_v);
        check("dr8_tms",  tms_v,  32'h0C01);
        check("dr8_tdi",  tdi_v,  32'h3D2F);
        check("dr8_busy", busy_v, 32'h1FFF);
        check("dr8_done", done_v, 32'h2000);
        check("dr8_so",   so_v,   32'hA5);

        // IR scan, len=5, 0x1F; busy exactly 11 cycles
        run_scan(1'b1, 6'd5, 32'h1F, 12, tms_v, tdi_v, busy_v, done_v, so_v);
        check("ir5_tms",   tms_v,  32'h303);
        check("ir5_tdi",   tdi_v,  32'hFFF);
        check("ir5_busy",  busy_v, 32'h7FF);
        check("ir5_done",  done_v, 32'h800);
        check("ir5_so",    so_v,   32'h1F);
        check("ir5_so_hold", bus.shift_out, 32'h1F);

        // Rejected lengths: 0 and 33
        for (int k = 0; k < 2; k++) begin
            bus.start    = 1'b1;
            bus.is_ir    = 1'b0;
            bus.len      = (k == 0) ? 6'd0 : 6'd33;
            bus.shift_in = 32'hFFFF_FFFF;
            tick();
            bus.start = 1'b0;
            $display("reject len=%0d err=%0d busy=%0d done=%0d tms=%0d", bus.len, bus.err, bus.busy, bus.done, tms);
            check("rej_err",  {31'd0, bus.err},  32'd1);
            check("rej_busy", {31'd0, bus.busy}, 32'd0);
            check("rej_done", {31'd0, bus.done}, 32'd0);
            check("rej_tms",  {31'd0, tms},      32'd0);
            tick();
            check("rej_err_end", {31'd0, bus.err},  32'd0);
            check("rej_busy2",   {31'd0, bus.busy}, 32'd0);
            check("rej_tms2",    {31'd0, tms},      32'd0);
            check("rej_so",      bus.shift_out,     32'h1F);
        end

        // TRST during shift bit 3 (cycle 7) of a len=16 DR scan
        bus.start    = 1'b1;
        bus.is_ir    = 1'b0;
        bus.len      = 6'd16;
        bus.shift_in = 32'hFFFF;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        check("abort_pre_tms",  {31'd0, tms},      32'd0);
        check("abort_pre_tdi",  {31'd0, tdi},      32'd1);
        check("abort_pre_busy", {31'd0, bus.busy}, 32'd1);
        #2 TRST = 1'b1;
        #1;
        $display("abort tms=%0d busy=%0d done=%0d shift_out=0x%0h", tms, bus.busy, bus.done, bus.shift_out);
        check("abort_tms",  {31'd0, tms},      32'd1);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_so",   bus.shift_out,     32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            check("abort_hold_done", {31'd0, bus.done}, 32'd0);
        end
        #2 TRST = 1'b0;
        tick();
`ifdef JTAG_MASTER_RESET_SEQ_EN
        check("abort_rel_tms",  {31'd0, tms},      32'd1);
        check("abort_rel_busy", {31'd0, bus.busy}, 32'd1);
        for (int c = 0; c < 6; c++) tick();
`endif
        check("abort_idle_tms",  {31'd0, tms},      32'd0);
        check("abort_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_idle_done", {31'd0, bus.done}, 32'd0);

        // Back-to-back: start held high through busy and into the done cycle
        bus.start    = 1'b1;
        bus.is_ir    = 1'b0;
        bus.len      = 6'd1;
        bus.shift_in = 32'h1;
        tick();
        tms_v = '0; tdi_v = '0; busy_v = '0; done_v = '0;
        for (int c = 0; c < 15; c++) begin
            tms_v[c]  = tms;
            tdi_v[c]  = tdi;
            busy_v[c] = bus.busy;
            done_v[c] = bus.done;
            if (c == 6)  check("b2b_so_done1",  bus.shift_out, 32'h1);
            if (c == 7)  check("b2b_so_clear",  bus.shift_out, 32'h0);
            if (c == 13) check("b2b_so_done2",  bus.shift_out, 32'h1);
            if (c == 12) bus.start = 1'b0;
            tick();
        end
        $display("b2b tms=0x%0h tdi=0x%0h busy=0x%0h done=0x%0h", tms_v, tdi_v, busy_v, done_v);
        check("b2b_tms",  tms_v,  32'h0C99);
        check("b2b_tdi",  tdi_v,  32'h7FFF);
        check("b2b_busy", busy_v, 32'h1FBF);
        check("b2b_done", done_v, 32'h2040);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
